// File: rtl/method_call_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : method_call_arbiter
// Description : Shares one exported method instance between NUM_REQ
//               requesters. Calls are granted round-robin and issued
//               combinationally. The index of each granted requester is
//               recorded in an in-order tag FIFO. Method results are routed
//               back to the owner at the tag FIFO head.
// Revision    : 1.0 - initial release
// ============================================================================
module method_call_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 32,
  parameter int TAG_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,               // active-low, asynchronous
  input  logic [NUM_REQ-1:0]            req_valid_in,
  input  logic [NUM_REQ*DATA_W-1:0]     req_x_in,
  output logic [NUM_REQ-1:0]            req_rdy_out,
  output logic [NUM_REQ-1:0]            rsp_valid_out,
  output logic [DATA_W-1:0]             rsp_result_out,
  input  logic [NUM_REQ-1:0]            rsp_rdy_in,
  output logic                          method_valid_out,
  output logic [DATA_W-1:0]             method_x_out,
  input  logic                          method_rdy_in,
  output logic                          method_rden_out,
  input  logic                          method_empty_in,
  input  logic [DATA_W-1:0]             method_result_in,
  output logic [$clog2(TAG_DEPTH):0]    outstanding_out,
  output logic                          tag_error_out
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_CNT   = CNT_W'(TAG_DEPTH);
  localparam logic [IDX_W:0]   NUM_REQ_EXT = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_REQ - 1);

  // Registered state
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic             tag_error_q, tag_error_d;
  logic [IDX_W-1:0] tag_mem_q [TAG_DEPTH];

  // Combinational
  logic             w_tag_full;
  logic             w_tag_empty;
  logic             w_call_ok;
  logic             w_grant_found;
  logic [IDX_W-1:0] w_grant_idx;
  logic [IDX_W:0]   w_arb_cand;
  logic [IDX_W-1:0] w_head_tag;
  logic             w_rsp_go;
  logic             w_push;
  logic             w_pop;

  // The occupancy count provides the full/empty distinction.
  // The pointers simply wrap modulo TAG_DEPTH.
  assign w_tag_full  = (outstanding_q == DEPTH_CNT);
  assign w_tag_empty = (outstanding_q == '0);

  // Calls are allowed only out of reset, with the method ready and a free tag slot.
  // A pop in the same cycle does not free a slot for this cycle's grant.
  assign w_call_ok = rst & method_rdy_in & ~w_tag_full;

  // Round-robin search that starts one past the last accepted grant.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_idx   = last_grant_q;
    w_arb_cand    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_arb_cand = {1'b0, last_grant_q} + (IDX_W+1)'(i);
      if (w_arb_cand >= NUM_REQ_EXT) begin
        w_arb_cand = w_arb_cand - NUM_REQ_EXT;
      end
      if (!w_grant_found && req_valid_in[w_arb_cand[IDX_W-1:0]]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = w_arb_cand[IDX_W-1:0];
      end
    end
  end

  // Call path: one-hot grant, and mux the granted argument onto the method.
  always_comb begin
    method_valid_out = w_call_ok & w_grant_found;
    req_rdy_out      = '0;
    method_x_out     = '0;
    if (method_valid_out) begin
      req_rdy_out[w_grant_idx] = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_grant_idx == IDX_W'(i)) begin
          method_x_out = req_x_in[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign w_head_tag = tag_mem_q[rd_ptr_q];

  // A result is routed only when the method has one and a tag is waiting for it.
  assign w_rsp_go = rst & ~method_empty_in & ~w_tag_empty;

  // Return path: present the result to the head owner, and pop when that owner accepts it.
  always_comb begin
    rsp_valid_out   = '0;
    rsp_result_out  = '0;
    method_rden_out = 1'b0;
    if (w_rsp_go) begin
      rsp_valid_out[w_head_tag] = 1'b1;
      rsp_result_out            = method_result_in;
      method_rden_out           = rsp_rdy_in[w_head_tag];
    end
  end

  assign w_push = method_valid_out;
  assign w_pop  = method_rden_out;

  // Next-state logic for the arbiter pointer, the tag FIFO bookkeeping and the sticky error flag.
  always_comb begin
    last_grant_d  = w_push ? w_grant_idx : last_grant_q;
    wr_ptr_d      = w_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d      = w_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    outstanding_d = outstanding_q;
    case ({w_push, w_pop})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
    // A result with no outstanding tag is an orphan.
    // Flag it, and never pop it.
    tag_error_d = tag_error_q | (~method_empty_in & w_tag_empty);
  end

  // State registers.
  // Reset discards every outstanding tag immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q  <= LAST_IDX;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      outstanding_q <= '0;
      tag_error_q   <= 1'b0;
    end else begin
      last_grant_q  <= last_grant_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      outstanding_q <= outstanding_d;
      tag_error_q   <= tag_error_d;
    end
  end

  // Tag storage.
  // It is cleared on reset so that the head tag is never unknown.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TAG_DEPTH; i++) begin
        tag_mem_q[i] <= '0;
      end
    end else if (w_push) begin
      tag_mem_q[wr_ptr_q] <= w_grant_idx;
    end
  end

  assign outstanding_out = outstanding_q;
  assign tag_error_out   = tag_error_q;

endmodule
`default_nettype wire

// File: tb/tb_method_call_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_method_call_arbiter
// Description : Self-checking scoreboard bench for method_call_arbiter, with a
//               simple method model that returns 5*x through a show-ahead FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_method_call_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 32;
  localparam int TAG_DEPTH = 16;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid_in;
  logic [NUM_REQ*DATA_W-1:0] req_x_in;
  logic [NUM_REQ-1:0]        req_rdy_out;
  logic [NUM_REQ-1:0]        rsp_valid_out;
  logic [DATA_W-1:0]         rsp_result_out;
  logic [NUM_REQ-1:0]        rsp_rdy_in;
  logic                      method_valid_out;
  logic [DATA_W-1:0]         method_x_out;
  logic                      method_rdy_in;
  logic                      method_rden_out;
  logic                      method_empty_in;
  logic [DATA_W-1:0]         method_result_in;
  logic [4:0]                outstanding_out;
  logic                      tag_error_out;

  always #5 clk = ~clk;

  method_call_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DATA_W    (DATA_W),
    .TAG_DEPTH (TAG_DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid_in     (req_valid_in),
    .req_x_in         (req_x_in),
    .req_rdy_out      (req_rdy_out),
    .rsp_valid_out    (rsp_valid_out),
    .rsp_result_out   (rsp_result_out),
    .rsp_rdy_in       (rsp_rdy_in),
    .method_valid_out (method_valid_out),
    .method_x_out     (method_x_out),
    .method_rdy_in    (method_rdy_in),
    .method_rden_out  (method_rden_out),
    .method_empty_in  (method_empty_in),
    .method_result_in (method_result_in),
    .outstanding_out  (outstanding_out),
    .tag_error_out    (tag_error_out)
  );

  // ---------------- method model: result = 5*x, show-ahead FIFO -------------
  logic [31:0] mq [256];
  int unsigned mq_wr, mq_rd;
  logic        hold;     // keep the FIFO looking empty
  logic        inject;   // present an orphan result

  assign method_empty_in  = !inject && (hold || (mq_wr == mq_rd));
  assign method_result_in = inject ? 32'hDEAD_BEEF : mq[mq_rd[7:0]];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq_wr <= 0;
      mq_rd <= 0;
    end else begin
      if (method_rden_out) mq_rd <= mq_rd + 1;
      if (method_valid_out && method_rdy_in) begin
        mq[mq_wr[7:0]] <= method_x_out * 32'd5;
        mq_wr <= mq_wr + 1;
      end
    end
  end

  // ---------------- scoreboard ----------------------------------------------
  typedef struct packed {
    logic [7:0]  idx;
    logic [31:0] val;
  } exp_t;

  exp_t exp_grant[$];
  exp_t exp_rsp[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h, required %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: actual event seen, required none", name);
  endtask

  task automatic expect_call(input int idx, input logic [31:0] x);
    exp_grant.push_back({8'(idx), x});
    exp_rsp.push_back({8'(idx), x * 32'd5});
  endtask

  // ---------------- monitor -------------------------------------------------
  exp_t       mon_e;
  logic [3:0] mon_hs;

  always @(negedge clk) begin
    if (rst) begin
      if (method_valid_out && method_rdy_in) begin
        if (exp_grant.size() == 0) begin
          fail_now("unexpected_grant");
        end else begin
          mon_e = exp_grant.pop_front();
          check("grant_onehot", 64'(req_rdy_out), 64'(1) << mon_e.idx);
          check("grant_x", 64'(method_x_out), 64'(mon_e.val));
        end
      end else begin
        check("idle_rdy_zero", 64'(req_rdy_out), 64'd0);
      end
      mon_hs = rsp_valid_out & rsp_rdy_in;
      check("rden_vs_handshake", 64'(method_rden_out), 64'(|mon_hs));
      if (mon_hs != 4'd0) begin
        if (exp_rsp.size() == 0) begin
          fail_now("unexpected_response");
        end else begin
          mon_e = exp_rsp.pop_front();
          check("rsp_owner", 64'(mon_hs), 64'(1) << mon_e.idx);
          check("rsp_data", 64'(rsp_result_out), 64'(mon_e.val));
        end
      end
    end
  end

  // ---------------- helpers -------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_x(input int i, input logic [31:0] v);
    req_x_in[i*DATA_W +: DATA_W] = v;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    exp_grant.delete();
    exp_rsp.delete();
    req_valid_in  = '0;
    hold          = 1'b0;
    inject        = 1'b0;
    rsp_rdy_in    = 4'hF;
    method_rdy_in = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((exp_rsp.size() != 0 || outstanding_out != 0) && k < 300) begin
      tick();
      k++;
    end
    @(negedge clk);
    check({name, "_grants_left"}, 64'(exp_grant.size()), 64'd0);
    check({name, "_rsps_left"}, 64'(exp_rsp.size()), 64'd0);
    check({name, "_outstanding"}, 64'(outstanding_out), 64'd0);
  endtask

  // ---------------- watchdog ------------------------------------------------
  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ------------------------------------------------
  initial begin
    int n0, n2;
    rst           = 1'b1;
    req_valid_in  = 4'hF;
    req_x_in      = '0;
    rsp_rdy_in    = 4'hF;
    method_rdy_in = 1'b1;
    hold          = 1'b0;
    inject        = 1'b0;
    #3 rst = 1'b0;
    #1;
    // Reset values, with requests active
    check("rst_req_rdy", 64'(req_rdy_out), 64'd0);
    check("rst_method_valid", 64'(method_valid_out), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid_out), 64'd0);
    check("rst_rden", 64'(method_rden_out), 64'd0);
    check("rst_outstanding", 64'(outstanding_out), 64'd0);
    check("rst_tag_error", 64'(tag_error_out), 64'd0);

    // Round robin with all four requesters continuous: 0,1,2,3,0,...
    do_reset();
    for (int i = 0; i < 4; i++) set_x(i, 32'(10 + i));
    for (int k = 0; k < 12; k++) expect_call(k % 4, 32'(10 + k % 4));
    req_valid_in = 4'hF;
    repeat (12) tick();
    req_valid_in = 4'h0;
    drain("rr");

    // Requester 0 (100..109) interleaved with requester 2 (0..9)
    do_reset();
    for (int k = 0; k < 20; k++) begin
      n0 = (k + 1) / 2;
      n2 = k / 2;
      set_x(0, 32'(100 + n0));
      set_x(2, 32'(n2));
      req_valid_in = {1'b0, (n2 < 10), 1'b0, (n0 < 10)};
      if (k % 2 == 0) expect_call(0, 32'(100 + k / 2));
      else            expect_call(2, 32'(k / 2));
      tick();
    end
    req_valid_in = 4'h0;
    drain("interleave");

    // Tag FIFO full: 16 grants, then no grant until the first pop
    do_reset();
    hold = 1'b1;
    for (int i = 0; i < 4; i++) set_x(i, 32'(10 + i));
    for (int k = 0; k < 16; k++) expect_call(k % 4, 32'(10 + k % 4));
    expect_call(0, 32'd10);
    req_valid_in = 4'hF;
    repeat (16) tick();
    repeat (3) begin
      @(negedge clk);
      check("full_outstanding", 64'(outstanding_out), 64'd16);
      check("full_req_rdy", 64'(req_rdy_out), 64'd0);
      tick();
    end
    hold = 1'b0;
    @(negedge clk);
    check("first_pop_rden", 64'(method_rden_out), 64'd1);
    check("first_pop_no_grant", 64'(req_rdy_out), 64'd0);
    tick();
    req_valid_in = 4'b0001;
    @(negedge clk);
    check("after_pop_outstanding", 64'(outstanding_out), 64'd15);
    tick();
    req_valid_in = 4'h0;
    drain("full");

    // Head owner stalls its result for five cycles
    do_reset();
    set_x(1, 32'd7);
    set_x(2, 32'd8);
    rsp_rdy_in = 4'b1101;
    expect_call(1, 32'd7);
    expect_call(2, 32'd8);
    req_valid_in = 4'b0110;
    tick();
    tick();
    req_valid_in = 4'h0;
    repeat (5) begin
      @(negedge clk);
      check("stall_rden", 64'(method_rden_out), 64'd0);
      check("stall_rsp_valid", 64'(rsp_valid_out), 64'b0010);
      tick();
    end
    rsp_rdy_in = 4'hF;
    drain("stall");

    // Orphan result sets the sticky tag error
    do_reset();
    inject = 1'b1;
    repeat (3) begin
      tick();
      @(negedge clk);
      check("orphan_tag_error", 64'(tag_error_out), 64'd1);
      check("orphan_outstanding", 64'(outstanding_out), 64'd0);
      check("orphan_rsp_valid", 64'(rsp_valid_out), 64'd0);
      check("orphan_rden", 64'(method_rden_out), 64'd0);
    end
    tick();
    inject = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("tag_error_sticky", 64'(tag_error_out), 64'd1);

    // Reset with 7 calls outstanding, then a fresh call
    do_reset();
    hold = 1'b1;
    set_x(3, 32'd9);
    for (int k = 0; k < 7; k++) expect_call(3, 32'd9);
    req_valid_in = 4'b1000;
    repeat (7) tick();
    req_valid_in = 4'h0;
    @(negedge clk);
    check("pre_reset_outstanding", 64'(outstanding_out), 64'd7);
    check("pre_reset_grants", 64'(exp_grant.size()), 64'd0);
    tick();
    req_valid_in = 4'hF;
    hold         = 1'b0;
    rst          = 1'b0;
    exp_grant.delete();
    exp_rsp.delete();
    #1;
    check("midrst_req_rdy", 64'(req_rdy_out), 64'd0);
    check("midrst_method_valid", 64'(method_valid_out), 64'd0);
    check("midrst_rsp_valid", 64'(rsp_valid_out), 64'd0);
    check("midrst_rden", 64'(method_rden_out), 64'd0);
    check("midrst_outstanding", 64'(outstanding_out), 64'd0);
    check("midrst_tag_error", 64'(tag_error_out), 64'd0);
    tick();
    tick();
    req_valid_in = 4'h0;
    rst = 1'b1;
    set_x(1, 32'd3);
    expect_call(1, 32'd3);
    req_valid_in = 4'b0010;
    tick();
    req_valid_in = 4'h0;
    drain("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/method_call_arbiter.md
METHOD_CALL_ARBITER -- requirements
Module: method_call_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one exported method instance (2..8).
REQ-002 Parameter DATA_W, default 32, width of the method argument and of its result.
REQ-003 Parameter TAG_DEPTH, default 16, maximum outstanding calls; power of two, 2..64.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 req_valid_in  input  NUM_REQ  per-requester call request.
REQ-007 req_x_in  input  NUM_REQ*DATA_W  per-requester argument; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-008 req_rdy_out  output  NUM_REQ  one-hot grant; call accepted when valid and rdy are both 1.
REQ-009 rsp_valid_out  output  NUM_REQ  one-hot result valid to the owning requester.
REQ-010 rsp_result_out  output  DATA_W  shared result bus.
REQ-011 rsp_rdy_in  input  NUM_REQ  per-requester result acceptance.
REQ-012 method_valid_out  output  1  call issue to the method.
REQ-013 method_x_out  output  DATA_W  argument of the issued call.
REQ-014 method_rdy_in  input  1  method can accept a call this cycle.
REQ-015 method_rden_out  output  1  pop of the method result FIFO.
REQ-016 method_empty_in  input  1  method result FIFO empty; method_result_in valid when 0 (show-ahead).
REQ-017 method_result_in  input  DATA_W  head of the method result FIFO.
REQ-018 outstanding_out  output  clog2(TAG_DEPTH)+1  calls issued whose results are not yet delivered.
REQ-019 tag_error_out  output  1  sticky: result arrived with no outstanding call.

Function
REQ-020 Arbitration shall be round-robin: search starts at requester (last_grant+1) mod NUM_REQ; last_grant updates only on an accepted call.
REQ-021 A grant shall occur only when method_rdy_in=1 and the tag FIFO is not full; a pop in the same cycle does not free a slot for that cycle's grant.
REQ-022 Call path shall be combinational: method_valid_out = OR of the request bits gated by the REQ-021 condition; method_x_out = argument of the granted requester; req_rdy_out = one-hot of the granted index, or 0.
REQ-023 Each accepted call shall push the granted requester index into a TAG_DEPTH-entry in-order tag FIFO.
REQ-024 Return path: when method_empty_in=0 and the tag FIFO is not empty, rsp_valid_out shall assert only the bit for the tag at the FIFO head, with rsp_result_out = method_result_in.
REQ-025 method_rden_out = rsp_valid_out[head] & rsp_rdy_in[head]; the tag FIFO pops in the same cycle; results are never dropped or reordered.
REQ-026 When method_empty_in=1 or the tag FIFO is empty, rsp_valid_out shall be 0; rsp_result_out is don't-care.
REQ-027 method_empty_in=0 with the tag FIFO empty shall set tag_error_out; no pop occurs and rsp_valid_out stays 0.
REQ-028 outstanding_out: +1 on push, -1 on pop, unchanged on simultaneous push and pop; range 0..TAG_DEPTH.
REQ-029 Tag FIFO pointers shall wrap modulo TAG_DEPTH with a separate full/empty distinction (extra pointer bit or count).
REQ-030 A request may be withdrawn before grant without effect; a non-granted requester shall not have its rdy asserted.

Reset
REQ-031 While rst=0: req_rdy_out=0, method_valid_out=0, rsp_valid_out=0, method_rden_out=0, outstanding_out=0, tag_error_out=0, tag FIFO empty, last_grant=NUM_REQ-1 (so requester 0 wins first).
REQ-032 Reset asserted mid-operation shall discard all outstanding tags immediately (asynchronously); the method instance must be reset concurrently.
REQ-033 Outputs shall be driven only from reset-cleared state or gated by it, so that no output carries X after reset.

Verification
REQ-034 All four requesters request continuously, method_rdy_in=1 -> grants 0,1,2,3,0,1,... one per cycle.
REQ-035 Requester 2 issues x=0..9 and requester 0 issues x=100..109 interleaved; method returns 5x in order -> requester 2 receives 0,5,...,45 and requester 0 receives 500,...,545, each exactly once, in order.
REQ-036 TAG_DEPTH=16, method results held (empty=1), requests continuous -> exactly 16 grants, outstanding_out=16, req_rdy_out=0 until the first pop; the first pop does not allow a grant in the same cycle.
REQ-037 Head requester holds rsp_rdy_in=0 for 5 cycles while others are ready -> method_rden_out=0 and no other requester receives a result during those cycles.
REQ-038 method_empty_in=0 with no call issued -> tag_error_out=1 and stays 1 until reset; outstanding_out remains 0.
REQ-039 Reset asserted with 7 calls outstanding -> all outputs take REQ-031 values in the same cycle; after release, a new call x=3 from requester 1 returns 15 to requester 1.
